// File: rtl/psk_phase_gen_if.sv
// Stream bundle for the PSK phase generator: symbol input stream and phase output stream.
// The master modport is the generator side; the slave modport is its environment.
interface psk_phase_gen_if #(
    parameter int PHASE_WIDTH = 16
);
    logic                   S_SYM_TVALID;
    logic                   S_SYM_TREADY;
    logic [2:0]             S_SYM_TDATA;
    logic                   M_AXIS_TVALID;
    logic                   M_AXIS_TREADY;
    logic [PHASE_WIDTH-1:0] M_AXIS_TDATA;

    modport master (
        input  S_SYM_TVALID, S_SYM_TDATA, M_AXIS_TREADY,
        output S_SYM_TREADY, M_AXIS_TVALID, M_AXIS_TDATA
    );

    modport slave (
        output S_SYM_TVALID, S_SYM_TDATA, M_AXIS_TREADY,
        input  S_SYM_TREADY, M_AXIS_TVALID, M_AXIS_TDATA
    );
endinterface

// File: rtl/psk_phase_gen.sv
// PSK phase generator: carrier phase accumulator plus per-symbol phase offset,
// streamed as one phase word per accepted beat, fed by a one-entry symbol buffer.
module psk_phase_gen #(
    parameter int PHASE_WIDTH   = 16,
    parameter int SYM_LEN_WIDTH = 16,
    parameter int GRAY_MAP      = 0
) (
    input  logic                     M_AXIS_ACLK,
    input  logic                     M_AXIS_ARESETN,
    input  logic                     gen_en,
    input  logic [1:0]               mode,
    input  logic [PHASE_WIDTH-1:0]   phase_inc,
    input  logic [SYM_LEN_WIDTH-1:0] sym_len,
    output logic                     underrun,
    psk_phase_gen_if.master          bus
);
    typedef enum logic [1:0] {IDLE, WAIT_SYM, RUN} state_t;

    localparam logic [SYM_LEN_WIDTH-1:0] LEN_ONE = 1;

    state_t                   state, state_n;
    logic [PHASE_WIDTH-1:0]   acc, acc_n, offset, offset_n, tdata, tdata_n;
    logic [SYM_LEN_WIDTH-1:0] cnt, cnt_n, len_q, len_n;
    logic [2:0]               buf_sym, buf_sym_n;
    logic                     buf_valid, buf_valid_n;
    logic                     s_rdy, tvalid, tvalid_n, underrun_n;
    logic                     beat_hs, last_beat;

    // Mode only matters when an offset is loaded, so it is sampled there.
    function automatic logic [PHASE_WIDTH-1:0] sym_offset(input logic [1:0] md,
                                                          input logic [2:0] sym);
        logic [2:0]  g, idx;
        int unsigned sh;
        case (md)
            2'd1:    begin g = {1'b0, sym[1:0]}; sh = PHASE_WIDTH - 2; end
            2'd2:    begin g = sym;              sh = PHASE_WIDTH - 3; end
            default: begin g = {2'b00, sym[0]};  sh = PHASE_WIDTH - 1; end
        endcase
        idx = (GRAY_MAP != 0) ? {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]} : g;
        return PHASE_WIDTH'(idx) << sh;
    endfunction

    assign bus.S_SYM_TREADY  = s_rdy;
    assign bus.M_AXIS_TVALID = tvalid;
    assign bus.M_AXIS_TDATA  = tdata;

    assign beat_hs   = tvalid && bus.M_AXIS_TREADY;
    assign last_beat = (len_q == '0) || (cnt == len_q - LEN_ONE);

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) state <= IDLE;
        else                 state <= state_n;
    end

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        cnt_n       = cnt;
        offset_n    = offset;
        len_n       = len_q;
        buf_valid_n = buf_valid;
        buf_sym_n   = buf_sym;
        tvalid_n    = tvalid;
        tdata_n     = tdata;
        underrun_n  = 1'b0;

        if (bus.S_SYM_TVALID && s_rdy) begin
            buf_valid_n = 1'b1;
            buf_sym_n   = bus.S_SYM_TDATA;
        end

        case (state)
            IDLE: begin
                tvalid_n = 1'b0;
                if (gen_en) begin
                    state_n = WAIT_SYM;
                    acc_n   = '0;
                    cnt_n   = '0;
                end
            end
            WAIT_SYM: begin
                if (!gen_en) begin
                    state_n = IDLE;
                end else if (buf_valid) begin
                    state_n     = RUN;
                    offset_n    = sym_offset(mode, buf_sym);
                    len_n       = sym_len;
                    buf_valid_n = 1'b0;
                    tvalid_n    = 1'b1;
                    tdata_n     = acc + offset_n;
                end
            end
            RUN: begin
                if (beat_hs) begin
                    acc_n = acc + phase_inc;
                    if (!gen_en) begin
                        // Stopping beat: the buffered symbol is left for the next run.
                        state_n  = IDLE;
                        tvalid_n = 1'b0;
                    end else begin
                        if (last_beat) begin
                            cnt_n = '0;
                            if (buf_valid) begin
                                offset_n    = sym_offset(mode, buf_sym);
                                len_n       = sym_len;
                                buf_valid_n = 1'b0;
                            end else begin
                                offset_n   = '0;
                                underrun_n = 1'b1;
                            end
                        end else begin
                            cnt_n = cnt + LEN_ONE;
                        end
                        tdata_n = acc_n + offset_n;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            acc       <= '0;
            cnt       <= '0;
            offset    <= '0;
            len_q     <= '0;
            buf_valid <= 1'b0;
            buf_sym   <= '0;
            s_rdy     <= 1'b0;
            tvalid    <= 1'b0;
            tdata     <= '0;
            underrun  <= 1'b0;
        end else begin
            acc       <= acc_n;
            cnt       <= cnt_n;
            offset    <= offset_n;
            len_q     <= len_n;
            buf_valid <= buf_valid_n;
            buf_sym   <= buf_sym_n;
            s_rdy     <= !buf_valid_n;
            tvalid    <= tvalid_n;
            tdata     <= tdata_n;
            underrun  <= underrun_n;
        end
    end
endmodule

// File: tb/tb_psk_phase_gen.sv
// Scoreboard bench for psk_phase_gen: expected phase words are computed per beat
// from the symbol list and pushed into a queue; a negedge monitor pops and compares.
module tb_psk_phase_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gen_en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] phase_inc = 16'h0;
    logic [15:0] sym_len = 16'd1;
    logic        underrun;

    psk_phase_gen_if #(.PHASE_WIDTH(16)) bus();

    psk_phase_gen #(.PHASE_WIDTH(16), .SYM_LEN_WIDTH(16), .GRAY_MAP(1)) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rst_n),
        .gen_en         (gen_en),
        .mode           (mode),
        .phase_inc      (phase_inc),
        .sym_len        (sym_len),
        .underrun       (underrun),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          ur_seen = 0;
    bit          mon_en = 1'b1;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: k bits per symbol, Gray index folded back to binary, scaled to 2^16/2^k.
    function automatic logic [15:0] model_off(input logic [1:0] md, input logic [2:0] s);
        int k, g, b;
        k = (md == 2'd1) ? 2 : (md == 2'd2) ? 3 : 1;
        g = int'(s) % (1 << k);
        b = 0;
        for (int sh = 0; sh < k; sh++) b = b ^ (g >> sh);
        return 16'(b * (65536 >> k));
    endfunction

    // Output monitor: pops on each handshake, checks holding while stalled, counts underruns.
    initial begin
        bit          held;
        logic [15:0] held_data;
        held = 1'b0;
        held_data = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held)
                    check("hold", {15'b0, bus.M_AXIS_TVALID, bus.M_AXIS_TDATA}, {15'b0, 1'b1, held_data});
                held = 1'b0;
                if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
                    if (mon_en) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected beat: got 0x%0h, want no beat", bus.M_AXIS_TDATA);
                        end else begin
                            check("beat", {16'b0, bus.M_AXIS_TDATA}, {16'b0, exp_q.pop_front()});
                        end
                    end
                end else if (bus.M_AXIS_TVALID) begin
                    held = 1'b1;
                    held_data = bus.M_AXIS_TDATA;
                end
                if (underrun) ur_seen++;
            end
        end
    end

    task automatic feed(input logic [2:0] s);
        int k;
        k = 0;
        bus.S_SYM_TVALID = 1'b1;
        bus.S_SYM_TDATA  = s;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.S_SYM_TREADY && k < 3000);
        check("sym ready", {31'b0, bus.S_SYM_TREADY}, 32'd1);
        @(posedge clk);
        #1;
        bus.S_SYM_TVALID = 1'b0;
    endtask

    // pol: 0 = random ready, 1 = ready only on a beat's second cycle, 2 = ready held high.
    // The run is stopped (gen_en low) while the last beat is pending, with a short stall.
    task automatic run_case(input string name, input logic [1:0] md, input int len,
                            input logic [15:0] inc, input int t, input int pol,
                            input logic [2:0] syms[$]);
        int eff, n, ur_exp, ur_base, done, cyc, stall, si;
        bit stopping, acc_now, pres;
        logic [15:0] off;
        eff = (len == 0) ? 1 : len;
        n = syms.size();
        for (int j = 0; j < t; j++) begin
            si  = j / eff;
            off = (si < n) ? model_off(md, syms[si]) : 16'h0;
            exp_q.push_back(16'(j * int'(inc) + int'(off)));
        end
        ur_exp = 0;
        for (int b = 1; b * eff <= t - 1; b++)
            if (b >= n) ur_exp++;
        ur_base   = ur_seen;
        mode      = md;
        sym_len   = 16'(len);
        phase_inc = inc;
        feed(syms[0]);
        gen_en = 1'b1;
        bus.M_AXIS_TREADY = (pol == 2);
        done = 0;
        fork
            for (int i = 1; i < n; i++) feed(syms[i]);
            begin
                cyc = 0;
                stall = 0;
                stopping = 1'b0;
                while (done < t && cyc < 3000) begin
                    @(negedge clk);
                    pres    = bus.M_AXIS_TVALID;
                    acc_now = pres && bus.M_AXIS_TREADY;
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (acc_now) done++;
                    if (!stopping && done >= t - 1) begin
                        gen_en   = 1'b0;
                        stopping = 1'b1;
                        stall    = $urandom_range(1, 3);
                    end
                    if (stopping && stall > 0) begin
                        bus.M_AXIS_TREADY = 1'b0;
                        stall--;
                    end else begin
                        case (pol)
                            0:       bus.M_AXIS_TREADY = ($urandom_range(0, 9) < 7);
                            1:       bus.M_AXIS_TREADY = pres && !acc_now;
                            default: bus.M_AXIS_TREADY = 1'b1;
                        endcase
                    end
                end
            end
        join
        check({name, " beats"}, done, t);
        repeat (3) @(posedge clk);
        #1;
        check({name, " idle"}, {31'b0, bus.M_AXIS_TVALID}, 32'd0);
        check({name, " drained"}, exp_q.size(), 32'd0);
        exp_q.delete();
        check({name, " underruns"}, ur_seen - ur_base, ur_exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] q[$];
        int len, n, t;
        bus.S_SYM_TVALID  = 1'b0;
        bus.S_SYM_TDATA   = 3'd0;
        bus.M_AXIS_TREADY = 1'b0;

        #12;
        check("rst tvalid", {31'b0, bus.M_AXIS_TVALID}, 32'd0);
        check("rst tdata", {16'b0, bus.M_AXIS_TDATA}, 32'd0);
        check("rst s_tready", {31'b0, bus.S_SYM_TREADY}, 32'd0);
        check("rst underrun", {31'b0, underrun}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("s_tready before edge", {31'b0, bus.S_SYM_TREADY}, 32'd0);
        @(posedge clk);
        #1;
        check("s_tready after edge", {31'b0, bus.S_SYM_TREADY}, 32'd1);

        // Enable with no symbol, then drop enable while waiting.
        gen_en = 1'b1;
        @(posedge clk);
        #1;
        gen_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("wait abort", {31'b0, bus.M_AXIS_TVALID}, 32'd0);

        q = {3'd0, 3'd1};
        run_case("bpsk", 2'd0, 4, 16'h0100, 8, 2, q);
        q = {3'd0, 3'd1, 3'd3, 3'd2};
        run_case("qpsk gray", 2'd1, 1, 16'h0000, 4, 1, q);
        q = {3'd1};
        run_case("underrun", 2'd0, 2, 16'($urandom), 4, 0, q);
        q = {3'd4};
        run_case("wrap stop", 2'd2, 8, 16'hFFFF, 3, 2, q);
        q = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
        run_case("len0", 2'($urandom_range(0, 3)), 0, 16'($urandom), 4, 1, q);

        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(2, 5);
            n   = $urandom_range(1, 4);
            t   = (n - 1) * len + 1 + $urandom_range(1, len + 2);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(3'($urandom_range(0, 7)));
            run_case("random", 2'($urandom_range(0, 3)), len, 16'($urandom), t,
                     ($urandom_range(0, 1) == 0) ? 0 : 2, q);
        end

        // Asynchronous reset in the middle of a run.
        mon_en    = 1'b0;
        mode      = 2'd0;
        sym_len   = 16'd16;
        phase_inc = 16'h0123;
        feed(3'd1);
        gen_en = 1'b1;
        bus.M_AXIS_TREADY = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid rst tvalid", {31'b0, bus.M_AXIS_TVALID}, 32'd0);
        check("mid rst tdata", {16'b0, bus.M_AXIS_TDATA}, 32'd0);
        check("mid rst s_tready", {31'b0, bus.S_SYM_TREADY}, 32'd0);
        check("mid rst underrun", {31'b0, underrun}, 32'd0);
        gen_en = 1'b0;
        bus.M_AXIS_TREADY = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("post rst tvalid", {31'b0, bus.M_AXIS_TVALID}, 32'd0);
        q = {3'd3, 3'd2};
        run_case("after reset", 2'd1, 3, 16'($urandom), 7, 0, q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
